logic_unit_bist: RTL
====================

# logic_unit_bist

Parametrised registered logic unit: two WIDTH-bit operands, eight selectable bitwise operations, one-cycle registered result with valid flag. Carries its own built-in self-test (BIST). When started, the BIST sweeps every OP × A × B combination through the same datapath register, checks each result against an independent expected-value path, and reports pass/fail plus an error count. It replaces single-function 2-input gate cells in designs that need wider operands, runtime operation select and on-chip exhaustive checking.

## Interface
- WIDTH, 4, operand/result width in bits; legal 1..6 (sweep length 8·2^(2·WIDTH) vectors)
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- OP  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 pass A, 7 NOT A
- IN_VALID  in  1  capture A/B/OP this cycle (functional mode)
- FAULT_INJ  in  1  inverts datapath result bit 0 (both modes); test aid only
- Y  out  WIDTH  registered result
- Y_VALID  out  1  Y updated this cycle from a functional capture
- BIST_START  in  1  start self-test; sampled in IDLE only
- BIST_BUSY  out  1  self-test in progress
- BIST_DONE  out  1  one-cycle pulse at end of self-test
- BIST_PASS  out  1  last self-test had zero errors; held until next start
- BIST_ERRCNT  out  16  mismatches in last self-test, saturating at 16'hFFFF

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: on an edge with IN_VALID=1, Y <= f(OP,A,B) (bit 0 XOR FAULT_INJ), Y_VALID <= 1. Otherwise Y holds and Y_VALID <= 0.
- IDLE with BIST_START=1 goes to SWEEP. Clear vector counter, BIST_ERRCNT, BIST_PASS. Set BIST_BUSY. BIST_START wins over IN_VALID in the same cycle.
- SWEEP: vector counter V (3+2·WIDTH bits) = {OP, A, B}, OP in the MSBs. One vector per cycle, starting at 0. Datapath register captures f(V) each cycle. Expected register captures the reference function of V in parallel; FAULT_INJ is not applied to expected. Move to DRAIN after the vector with V all-ones is issued.
- Compare stage: one cycle after each capture, datapath register != expected register increments BIST_ERRCNT, saturating.
- DRAIN: one cycle for the final compare, then DONE.
- DONE: BIST_DONE=1 for one cycle. BIST_PASS <= (final count == 0). BIST_BUSY <= 0. Return to IDLE.
- During SWEEP/DRAIN/DONE: IN_VALID and BIST_START ignored, Y_VALID held 0. Y shows sweep results and is don't-care to the consumer.
- Reference function uses a separate case statement from the datapath. Both are bitwise, with no carries.

## Timing
- Reset values: Y=0, Y_VALID=0, BIST_BUSY=0, BIST_DONE=0, BIST_PASS=0, BIST_ERRCNT=0. FSM goes to IDLE.
- RST is asynchronous at any time, including mid-sweep. Everything clears immediately, and no BIST_DONE pulse follows.
- Functional latency: 1 cycle (capture at edge k, Y/Y_VALID visible after edge k). Throughput: 1 per cycle.
- BIST, with N = 8·2^(2·WIDTH) and BIST_START sampled at edge s:
  - BUSY high after edge s.
  - Vector i captured at edge s+1+i.
  - DRAIN occupies the cycle after edge s+N.
  - BIST_DONE high after edge s+N+2 for one cycle.
  - BUSY low and PASS/ERRCNT final after edge s+N+2.
  - Total N+2 cycles from start to DONE.
- BIST_ERRCNT is valid only once BIST_DONE has been seen. It holds until the next BIST_START.

## Test plan
- Reset then functional sweep, WIDTH=4: A=4'b1100, B=4'b1010, IN_VALID=1, OP=0..7 on consecutive cycles. Required Y sequence, each one cycle late with Y_VALID=1: 1000, 1110, 0110, 0111, 0001, 1001, 1100, 0011.
- Hold: IN_VALID=0 after a capture -> Y unchanged, Y_VALID=0 next cycle.
- Clean BIST, WIDTH=2 (N=128): pulse BIST_START -> BUSY for 130 cycles, single BIST_DONE pulse, BIST_PASS=1, BIST_ERRCNT=0, Y_VALID=0 throughout. Assert IN_VALID mid-sweep -> no effect.
- Fault BIST, WIDTH=2: FAULT_INJ=1 for the whole sweep -> BIST_ERRCNT=128, BIST_PASS=0. Re-run with FAULT_INJ=0 -> ERRCNT=0, PASS=1.
- Reset mid-sweep: assert RST at vector 50 -> all outputs 0 immediately, no BIST_DONE. A new BIST_START then gives a full 130-cycle run.
- Collision: BIST_START and IN_VALID in the same IDLE cycle -> BIST starts, Y_VALID stays 0. A BIST_START pulse while BUSY -> ignored, only one BIST_DONE.

Source files
------------

// File: rtl/logic_unit_bist.sv
// logic_unit_bist: registered WIDTH-bit bitwise logic unit with eight selectable
// operations and an exhaustive built-in self-test that sweeps every {OP, A, B}
// vector through the result register and checks it against an independent
// truth-table reference.
module logic_unit_bist #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_in_valid,
  input  logic             i_fault_inj,
  output logic [WIDTH-1:0] o_y,
  output logic             o_y_valid,
  input  logic             i_bist_start,
  output logic             o_bist_busy,
  output logic             o_bist_done,
  output logic             o_bist_pass,
  output logic [15:0]      o_bist_errcnt
);

  localparam int VW = 3 + 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Datapath function: direct bitwise operators.
  function automatic logic [WIDTH-1:0] f_datapath(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = a;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Reference function: per-bit truth-table lookup indexed by {a_bit, b_bit},
  // deliberately structured differently from the datapath so a shared mistake
  // is unlikely.
  function automatic logic [WIDTH-1:0] f_reference(input logic [2:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [3:0]       tt;
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b1100;
      default: tt = 4'b0011;
    endcase
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = tt[{a[i], b[i]}];
    end
    return r;
  endfunction

  state_t           r_state;
  logic [VW-1:0]    r_vec;
  logic [WIDTH-1:0] r_y_p0;
  logic [WIDTH-1:0] r_exp_p0;
  logic             r_cmp_p0;
  logic             r_y_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_errcnt;

  logic [2:0]       w_vec_op;
  logic [WIDTH-1:0] w_vec_a;
  logic [WIDTH-1:0] w_vec_b;
  logic [WIDTH-1:0] w_fault_mask;
  logic             w_mismatch;
  logic             w_vec_last;

  // Sweep vector layout is {OP, A, B} with OP in the MSBs.
  assign w_vec_op     = r_vec[VW-1 -: 3];
  assign w_vec_a      = r_vec[2*WIDTH-1 -: WIDTH];
  assign w_vec_b      = r_vec[WIDTH-1:0];
  assign w_fault_mask = WIDTH'(i_fault_inj);
  assign w_mismatch   = r_cmp_p0 && (r_y_p0 != r_exp_p0);
  assign w_vec_last   = &r_vec;

  // Control FSM plus result register; the result register is shared by
  // functional captures and the self-test sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_vec     <= '0;
      r_y_p0    <= '0;
      r_cmp_p0  <= 1'b0;
      r_y_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_errcnt  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cmp_p0  <= 1'b0;
      r_y_valid <= 1'b0;
      // compare stage: result/expected pair captured on the previous edge
      if (w_mismatch && (r_errcnt != 16'hFFFF)) begin
        r_errcnt <= r_errcnt + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (i_bist_start) begin
            r_state  <= SWEEP;
            r_vec    <= '0;
            r_errcnt <= '0;
            r_pass   <= 1'b0;
            r_busy   <= 1'b1;
          end else if (i_in_valid) begin
            r_y_p0    <= f_datapath(i_op, i_a, i_b) ^ w_fault_mask;
            r_y_valid <= 1'b1;
          end
        end
        SWEEP: begin
          r_y_p0   <= f_datapath(w_vec_op, w_vec_a, w_vec_b) ^ w_fault_mask;
          r_cmp_p0 <= 1'b1;
          r_vec    <= r_vec + 1'b1;
          if (w_vec_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= DONE;
        end
        default: begin
          r_done  <= 1'b1;
          r_pass  <= (r_errcnt == 16'd0);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Expected-value register; pure data, follows the sweep vector.
  always_ff @(posedge i_clk) begin
    if (r_state == SWEEP) begin
      r_exp_p0 <= f_reference(w_vec_op, w_vec_a, w_vec_b);
    end
  end

  assign o_y           = r_y_p0;
  assign o_y_valid     = r_y_valid;
  assign o_bist_busy   = r_busy;
  assign o_bist_done   = r_done;
  assign o_bist_pass   = r_pass;
  assign o_bist_errcnt = r_errcnt;

endmodule
